matrix_mem_responder: RTL
=========================

# matrix_mem_responder

Memory-side responder for the execution engine's matrix-memory handshake: it accepts enable/read-write/address requests, reads or writes one 256-bit matrix word (sixteen 16-bit elements) after a fixed latency, and acknowledges with a level flag held until the requester drops enable. It sits between the execution engine's `memEN`/`memRW`/`memAddr`/`toMemBus` outputs and its `fromMemBus`/`memFleg` inputs, replacing the behavioural memory used in early bring-up.

## Interface
- `DATA_W`, 256: word width (one 4x4 matrix of 16-bit elements).
- `ADDR_W`, 8: address width.
- `DEPTH`, 256: number of implemented words; must be at most 2^ADDR_W.
- `LATENCY`, 2: cycles from request capture to access and ack; must be at least 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `RESET`  in  1  reset, asynchronous, active-high.
- `memEN`  in  1  request enable, level; a new request starts when it is sampled high in IDLE.
- `memRW`  in  1  1 = read, 0 = write; sampled with `memEN`.
- `memAddr`  in  ADDR_W  word address; sampled with `memEN`.
- `toMemBus`  in  DATA_W  write data; sampled with `memEN`.
- `fromMemBus`  out  DATA_W  read data; valid while `memFleg` = 1 after a read.
- `memFleg`  out  1  acknowledge, level.
- `memErr`  out  1  high together with `memFleg` when the captured address is at least DEPTH.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ACCESS, ACK.
- IDLE: when `memEN` = 1, capture `memRW`, `memAddr` and `toMemBus` into internal registers, load the counter with LATENCY-1, and go to ACCESS.
- ACCESS: while the counter is nonzero, decrement it. When the counter is 0, perform the access using the captured values, set `memFleg` = 1, and go to ACK.
  - Read: `fromMemBus` <= mem[addr].
  - Write: mem[addr] <= data; `fromMemBus` holds its previous value.
  - Address at least DEPTH: no write is performed, `fromMemBus` <= 0, and `memErr` <= 1.
- ACK: hold `memFleg`, `memErr` and `fromMemBus`. When `memEN` is sampled 0, clear `memFleg` and `memErr` and return to IDLE.
- Inputs are ignored outside IDLE. Changing `memAddr`, `memRW` or `toMemBus` mid-transaction has no effect.
- If `memEN` falls during ACCESS, the transaction still completes (a write is committed). `memFleg` is then high for exactly one cycle.
- A new request needs `memEN` sampled high in IDLE. IDLE always lasts at least one cycle, so `memEN` held continuously high does not start back-to-back transactions.
- Storage contents are not initialised or cleared by RESET.

## Timing
- Reset values: `memFleg` 0, `memErr` 0, `busy` 0, `fromMemBus` 0, state IDLE, counter 0.
- RESET asserted mid-transaction aborts it.
  - A write is committed only if the access edge occurred before RESET asserted.
  - Outputs return to their reset values immediately (asynchronous reset).
- Request captured at edge N:
  - `busy` = 1 after edge N.
  - Access and `memFleg` rise after edge N+LATENCY.
  - Read data is valid in the same cycle that `memFleg` rises.
- With `memEN` sampled 0 at edge M in ACK: `memFleg` = 0 and `busy` = 0 after edge M.
- Earliest next capture is edge M+1. Minimum transaction is LATENCY+2 cycles.

## Structure
- Package `mem_pkg` contains:
  - the state enum (IDLE, ACCESS, ACK);
  - constants `MEM_READ` = 1 and `MEM_WRITE` = 0;
  - the `DATA_W` and `ADDR_W` defaults shared with the execution engine.
- Sub-module `matrix_mem_array`: single-port synchronous storage (DEPTH x DATA_W) with write enable and registered read. The FSM, counter and address-range check stay in `matrix_mem_responder`.

## Test plan
- Reset: assert RESET asynchronously mid-cycle -> `memFleg`, `memErr`, `busy` and `fromMemBus` all 0 immediately.
- Write then read:
  - Write 256'h0001_0002_..._0010 to address 8'h05, LATENCY = 2 -> `memFleg` rises 2 edges after capture and stays high until `memEN` drops.
  - Read address 8'h05 -> `fromMemBus` = 256'h0001_0002_..._0010 when `memFleg` rises.
- Ack hold: keep `memEN` high for 5 cycles after `memFleg` rises -> `memFleg` stays 1 for all 5 cycles, no second transaction starts, and `busy` falls on the edge that samples `memEN` = 0.
- Early enable drop: drop `memEN` one cycle after capture of a write of 256'hFFFF...FFFF to 8'h10 -> `memFleg` pulses for exactly one cycle, and a later read of 8'h10 returns all ones.
- Out of range: DEPTH = 16, read address 8'h20 -> `memErr` = 1 and `fromMemBus` = 0 together with `memFleg`. A write to 8'h20 leaves addresses 8'h00 to 8'h0F unchanged.
- Reset mid-access: assert RESET in ACCESS during a write to 8'h03 -> no ack, address 8'h03 keeps its old value, and the next request completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the matrix-memory handshake between the
// execution engine and its memory-side responder.
package mem_pkg;

    // Word and address widths shared with the execution engine
    localparam int unsigned MEM_DATA_W = 256;
    localparam int unsigned MEM_ADDR_W = 8;

    // memRW encoding
    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    // Responder handshake states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

endpackage

// File: rtl/matrix_mem_array.sv
// Single-port synchronous storage with a registered read port.
// The read register can also be cleared, which the responder uses to
// present zero data for out-of-range accesses.
module matrix_mem_array #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = 8
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Next read-register value: load on read, zero on clear, else hold
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end else if (clr) begin
            rdata_d = '0;
        end
    end

    // Read register with asynchronous reset
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/matrix_mem_responder.sv
// Memory-side responder for the execution engine's matrix-memory
// handshake: captures a request, waits LATENCY cycles, performs the
// read or write, then holds memFleg until memEN is dropped.
module matrix_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = MEM_DATA_W,
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              memEN,
    input  logic              memRW,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] toMemBus,
    output logic [DATA_W-1:0] fromMemBus,
    output logic              memFleg,
    output logic              memErr,
    output logic              busy
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fleg_q, fleg_d;
    logic              err_q, err_d;
    logic              access;
    logic              in_range;

    assign in_range = (32'(addr_q) < DEPTH);

    // Handshake FSM: capture in IDLE, count down in ACCESS, hold in ACK
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fleg_d  = fleg_q;
        err_d   = err_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (memEN) begin
                    rw_d    = memRW;
                    addr_d  = memAddr;
                    wdata_d = toMemBus;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access  = 1'b1;
                    fleg_d  = 1'b1;
                    err_d   = !in_range;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!memEN) begin
                    fleg_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and capture registers with asynchronous reset
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= MEM_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            fleg_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fleg_q  <= fleg_d;
            err_q   <= err_d;
        end
    end

    matrix_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .RESET (RESET),
        .we    (access && in_range && (rw_q == MEM_WRITE)),
        .re    (access && in_range && (rw_q == MEM_READ)),
        .clr   (access && !in_range),
        .addr  (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .rdata (fromMemBus)
    );

    assign memFleg = fleg_q;
    assign memErr  = err_q;
    assign busy    = (state_q != IDLE);

endmodule
